rv32i_writeback: RTL and testbench

RV32I_WRITEBACK -- requirements
Module: rv32i_writeback

---
 rtl/rv32i_writeback_pkg.sv | 28 ++
 rtl/rv32i_load_align.sv | 40 ++++
 rtl/rv32i_writeback.sv | 104 ++++++++++
 tb/tb_rv32i_writeback.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_writeback_pkg.sv
// Shared definitions for the RV32I writeback stage: load funct3 codes,
// FSM state encoding and the context captured for a load awaiting its data.
package rv32i_writeback_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_WAIT_ACK = 1'b1
    } wb_state_t;

    typedef struct packed {
        logic [2:0] funct3;
        logic [1:0] lsb;
        logic [4:0] rd_addr;
        logic       wr_rd;
    } load_ctx_t;

    // x0 is hardwired to zero, so a completion targeting it never writes.
    function automatic logic writes_reg(input logic wr_rd, input logic [4:0] rd_addr);
        return wr_rd && (rd_addr != 5'd0);
    endfunction

endpackage

// File: rtl/rv32i_load_align.sv
// Combinational load extraction: selects the byte/half/word addressed by lsb
// from the memory word and sign- or zero-extends it according to funct3.
module rv32i_load_align
    import rv32i_writeback_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lsb,
    input  logic [31:0] word,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
    always_comb begin
        byte_sel = word[7:0];
        case (lsb)
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            2'd3:    byte_sel = word[31:24];
            default: byte_sel = word[7:0];
        endcase
    end

    // Halfword selection looks only at lsb[1]; a misaligned lsb[0] is ignored.
    assign half_sel = lsb[1] ? word[31:16] : word[15:0];

    always_comb begin
        data = word;
        case (funct3)
            F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   data = {{16{half_sel[15]}}, half_sel};
            F3_LBU:  data = {24'd0, byte_sel};
            F3_LHU:  data = {16'd0, half_sel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/rv32i_writeback.sv
// RV32I writeback stage: retires non-load results immediately and loads either
// on a same-cycle ack or after waiting in WAIT_ACK, pulsing the register-file write.
module rv32i_writeback
    import rv32i_writeback_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_ce,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic        i_is_load,
    input  logic        i_wr_rd,
    input  logic [2:0]  i_funct3,
    input  logic [4:0]  i_rd_addr,
    input  logic [31:0] i_result,
    input  logic [1:0]  i_addr_lsb,
    input  logic [31:0] i_dmem_data,
    input  logic        i_dmem_ack,
    output logic        o_wr,
    output logic [4:0]  o_rd_addr,
    output logic [31:0] o_rd,
    output logic        o_stall
);

    wb_state_t state, state_next;
    load_ctx_t pend, pend_next;
    load_ctx_t cmp_ctx;
    logic      cmp_is_load;
    logic      accept;
    logic      complete;
    logic      do_write;
    logic [31:0] load_data;
    logic [31:0] cmp_data;

    assign accept = (state == ST_IDLE) && i_ce && !i_stall && !i_flush;

    always_comb begin
        state_next  = state;
        pend_next   = pend;
        complete    = 1'b0;
        cmp_ctx     = pend;
        cmp_is_load = 1'b1;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    cmp_ctx = '{funct3: i_funct3, lsb: i_addr_lsb,
                                rd_addr: i_rd_addr, wr_rd: i_wr_rd};
                    cmp_is_load = i_is_load;
                    if (!i_is_load || i_dmem_ack) begin
                        complete = 1'b1;
                    end else begin
                        state_next = ST_WAIT_ACK;
                        pend_next  = cmp_ctx;
                    end
                end
            end
            // The pending load is older than any flush/stall, so only the ack matters here.
            ST_WAIT_ACK: begin
                if (i_dmem_ack) begin
                    complete   = 1'b1;
                    state_next = ST_IDLE;
                    pend_next  = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                pend_next  = '0;
            end
        endcase
    end

    rv32i_load_align u_load_align (
        .funct3 (cmp_ctx.funct3),
        .lsb    (cmp_ctx.lsb),
        .word   (i_dmem_data),
        .data   (load_data)
    );

    assign cmp_data = cmp_is_load ? load_data : i_result;
    assign do_write = complete && writes_reg(cmp_ctx.wr_rd, cmp_ctx.rd_addr);

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    // NOTE: all flops, including the captured load context, are reset so a load pending at reset is dropped.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state     <= ST_IDLE;
            pend      <= '0;
            o_wr      <= 1'b0;
            o_rd_addr <= 5'd0;
            o_rd      <= 32'd0;
            o_stall   <= 1'b0;
        end else begin
            state   <= state_next;
            pend    <= pend_next;
            o_wr    <= do_write;
            o_stall <= (state_next == ST_WAIT_ACK);
            if (do_write) begin
                o_rd      <= cmp_data;
                o_rd_addr <= cmp_ctx.rd_addr;
            end
        end
    end

endmodule

// File: tb/tb_rv32i_writeback.sv
// Self-checking bench for rv32i_writeback: directed scenarios plus a randomized
// run scored against a behavioural model of the writeback rules.
module tb_rv32i_writeback;

    logic        i_clk;
    logic        i_rstn;
    logic        i_ce;
    logic        i_stall;
    logic        i_flush;
    logic        i_is_load;
    logic        i_wr_rd;
    logic [2:0]  i_funct3;
    logic [4:0]  i_rd_addr;
    logic [31:0] i_result;
    logic [1:0]  i_addr_lsb;
    logic [31:0] i_dmem_data;
    logic        i_dmem_ack;
    logic        o_wr;
    logic [4:0]  o_rd_addr;
    logic [31:0] o_rd;
    logic        o_stall;

    int total = 0;
    int bad   = 0;

    rv32i_writeback dut (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_ce        (i_ce),
        .i_stall     (i_stall),
        .i_flush     (i_flush),
        .i_is_load   (i_is_load),
        .i_wr_rd     (i_wr_rd),
        .i_funct3    (i_funct3),
        .i_rd_addr   (i_rd_addr),
        .i_result    (i_result),
        .i_addr_lsb  (i_addr_lsb),
        .i_dmem_data (i_dmem_data),
        .i_dmem_ack  (i_dmem_ack),
        .o_wr        (o_wr),
        .o_rd_addr   (o_rd_addr),
        .o_rd        (o_rd),
        .o_stall     (o_stall)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_ce = 0; i_stall = 0; i_flush = 0; i_is_load = 0; i_wr_rd = 0;
        i_funct3 = 3'd0; i_rd_addr = 5'd0; i_result = 32'd0; i_addr_lsb = 2'd0;
        i_dmem_data = 32'd0; i_dmem_ack = 0;
    endtask

    task automatic drive(input logic ce, input logic is_load, input logic wr_rd,
                         input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] res,
                         input logic [1:0] lsb, input logic [31:0] mem, input logic ack);
        i_ce = ce; i_is_load = is_load; i_wr_rd = wr_rd; i_funct3 = f3; i_rd_addr = rd;
        i_result = res; i_addr_lsb = lsb; i_dmem_data = mem; i_dmem_ack = ack;
    endtask

    // Load extraction computed from shifts and arithmetic extension.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] lsb,
                                             input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * lsb)) & 32'hFF;
        h = (w >> (16 * lsb[1])) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
            3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    task automatic do_reset();
        clear_inputs();
        i_rstn = 1'b0;
        tick();
        tick();
        i_rstn = 1'b1;
    endtask

    task automatic test_reset();
        logic [38:0] want;
        clear_inputs();
        i_rstn = 1'b1;
        #2;
        i_rstn = 1'b0;
        #1;
        want = {1'b0, 1'b0, 5'd0, 32'd0};
        total++;
        if ({o_wr, o_stall, o_rd_addr, o_rd} !== want) begin
            bad++;
            $display("FAIL reset_async: got wr=%b stall=%b addr=%0d rd=%h want wr=%b stall=%b addr=%0d rd=%h",
                     o_wr, o_stall, o_rd_addr, o_rd, want[38], want[37], want[36:32], want[31:0]);
        end
        tick();
        tick();
        i_rstn = 1'b1;
        tick();
        total++;
        if ({o_wr, o_stall, o_rd_addr, o_rd} !== want) begin
            bad++;
            $display("FAIL reset_release: got wr=%b stall=%b addr=%0d rd=%h want wr=%b stall=%b addr=%0d rd=%h",
                     o_wr, o_stall, o_rd_addr, o_rd, want[38], want[37], want[36:32], want[31:0]);
        end
    endtask

    task automatic test_alu();
        logic [38:0] want;
        drive(1, 0, 1, 3'd0, 5'd5, 32'h1234_5678, 2'd0, 32'hFFFF_FFFF, 1);
        tick();
        clear_inputs();
        want = {1'b1, 1'b0, 5'd5, 32'h1234_5678};
        total++;
        if ({o_wr, o_stall, o_rd_addr, o_rd} !== want) begin
            bad++;
            $display("FAIL alu_write: got wr=%b stall=%b addr=%0d rd=%h want wr=%b stall=%b addr=%0d rd=%h",
                     o_wr, o_stall, o_rd_addr, o_rd, want[38], want[37], want[36:32], want[31:0]);
        end
        tick();
        want = {1'b0, 1'b0, 5'd5, 32'h1234_5678};
        total++;
        if ({o_wr, o_stall, o_rd_addr, o_rd} !== want) begin
            bad++;
            $display("FAIL alu_pulse_end: got wr=%b stall=%b addr=%0d rd=%h want wr=%b stall=%b addr=%0d rd=%h",
                     o_wr, o_stall, o_rd_addr, o_rd, want[38], want[37], want[36:32], want[31:0]);
        end
    endtask

    task automatic test_load_ack();
        logic [2:0]  f3s  [4] = '{3'd0, 3'd4, 3'd2, 3'd5};
        logic [31:0] exps [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h80FF_7F01, 32'h0000_80FF};
        logic [1:0]  lsbs [4] = '{2'd3, 2'd3, 2'd0, 2'd3};
        logic [38:0] want;
        for (int k = 0; k < 4; k++) begin
            drive(1, 1, 1, f3s[k], 5'd7, 32'h0BAD_0BAD, lsbs[k], 32'h80FF_7F01, 1);
            tick();
            clear_inputs();
            want = {1'b1, 1'b0, 5'd7, exps[k]};
            total++;
            if ({o_wr, o_stall, o_rd_addr, o_rd} !== want) begin
                bad++;
                $display("FAIL load_ack[%0d]: got wr=%b stall=%b addr=%0d rd=%h want wr=%b stall=%b addr=%0d rd=%h",
                         k, o_wr, o_stall, o_rd_addr, o_rd, want[38], want[37], want[36:32], want[31:0]);
            end
        end
    endtask

    task automatic test_load_delayed();
        logic [38:0] want;
        drive(1, 1, 1, 3'd1, 5'd9, 32'h0, 2'd2, 32'h8001_0000, 0);
        tick();
        clear_inputs();
        for (int k = 0; k < 3; k++) begin
            want = {1'b0, 1'b1, 5'd7, 32'h0000_80FF};
            total++;
            if ({o_wr, o_stall, o_rd_addr, o_rd} !== want) begin
                bad++;
                $display("FAIL load_wait[%0d]: got wr=%b stall=%b addr=%0d rd=%h want wr=%b stall=%b addr=%0d rd=%h",
                         k, o_wr, o_stall, o_rd_addr, o_rd, want[38], want[37], want[36:32], want[31:0]);
            end
            if (k < 2) begin
                i_ce = 1; i_result = 32'h1111_1111; i_rd_addr = 5'd3; i_wr_rd = 1;
                tick();
                clear_inputs();
            end
        end
        i_dmem_ack = 1; i_dmem_data = 32'h8001_0000; i_funct3 = 3'd2; i_addr_lsb = 2'd0;
        tick();
        clear_inputs();
        want = {1'b1, 1'b0, 5'd9, 32'hFFFF_8001};
        total++;
        if ({o_wr, o_stall, o_rd_addr, o_rd} !== want) begin
            bad++;
            $display("FAIL load_delayed_done: got wr=%b stall=%b addr=%0d rd=%h want wr=%b stall=%b addr=%0d rd=%h",
                     o_wr, o_stall, o_rd_addr, o_rd, want[38], want[37], want[36:32], want[31:0]);
        end
    endtask

    task automatic test_no_write();
        logic [38:0] want;
        want = {1'b0, 1'b0, 5'd9, 32'hFFFF_8001};
        for (int k = 0; k < 5; k++) begin
            clear_inputs();
            case (k)
                0: drive(1, 0, 1, 3'd0, 5'd0, 32'hAAAA_AAAA, 2'd0, 32'h0, 0);
                1: begin drive(1, 0, 1, 3'd0, 5'd3, 32'h5555_5555, 2'd0, 32'h0, 0); i_flush = 1; end
                2: begin drive(1, 1, 1, 3'd2, 5'd4, 32'h0, 2'd0, 32'h1234_0000, 1); i_stall = 1; end
                3: drive(1, 0, 0, 3'd0, 5'd6, 32'h6666_6666, 2'd0, 32'h0, 0);
                default: drive(0, 1, 1, 3'd2, 5'd8, 32'h0, 2'd0, 32'hCAFE_F00D, 1);
            endcase
            tick();
            clear_inputs();
            total++;
            if ({o_wr, o_stall, o_rd_addr, o_rd} !== want) begin
                bad++;
                $display("FAIL no_write[%0d]: got wr=%b stall=%b addr=%0d rd=%h want wr=%b stall=%b addr=%0d rd=%h",
                         k, o_wr, o_stall, o_rd_addr, o_rd, want[38], want[37], want[36:32], want[31:0]);
            end
        end
    endtask

    task automatic test_flush_in_wait();
        logic [38:0] want;
        drive(1, 1, 1, 3'd2, 5'd11, 32'h0, 2'd0, 32'h0, 0);
        tick();
        drive(1, 0, 1, 3'd0, 5'd12, 32'h2222_2222, 2'd0, 32'h0, 0);
        i_flush = 1;
        tick();
        want = {1'b0, 1'b1, 5'd9, 32'hFFFF_8001};
        total++;
        if ({o_wr, o_stall, o_rd_addr, o_rd} !== want) begin
            bad++;
            $display("FAIL flush_wait_hold: got wr=%b stall=%b addr=%0d rd=%h want wr=%b stall=%b addr=%0d rd=%h",
                     o_wr, o_stall, o_rd_addr, o_rd, want[38], want[37], want[36:32], want[31:0]);
        end
        i_dmem_ack = 1; i_dmem_data = 32'hDEAD_BEEF; i_stall = 1;
        tick();
        clear_inputs();
        want = {1'b1, 1'b0, 5'd11, 32'hDEAD_BEEF};
        total++;
        if ({o_wr, o_stall, o_rd_addr, o_rd} !== want) begin
            bad++;
            $display("FAIL flush_wait_commit: got wr=%b stall=%b addr=%0d rd=%h want wr=%b stall=%b addr=%0d rd=%h",
                     o_wr, o_stall, o_rd_addr, o_rd, want[38], want[37], want[36:32], want[31:0]);
        end
    endtask

    task automatic test_reset_in_wait();
        logic [38:0] want;
        drive(1, 1, 1, 3'd2, 5'd13, 32'h0, 2'd0, 32'h0, 0);
        tick();
        clear_inputs();
        i_rstn = 1'b0;
        #1;
        want = {1'b0, 1'b0, 5'd0, 32'd0};
        total++;
        if ({o_wr, o_stall, o_rd_addr, o_rd} !== want) begin
            bad++;
            $display("FAIL reset_wait_clear: got wr=%b stall=%b addr=%0d rd=%h want wr=%b stall=%b addr=%0d rd=%h",
                     o_wr, o_stall, o_rd_addr, o_rd, want[38], want[37], want[36:32], want[31:0]);
        end
        tick();
        i_rstn = 1'b1;
        i_dmem_ack = 1; i_dmem_data = 32'h7777_7777;
        tick();
        clear_inputs();
        total++;
        if ({o_wr, o_stall, o_rd_addr, o_rd} !== want) begin
            bad++;
            $display("FAIL reset_wait_stray_ack: got wr=%b stall=%b addr=%0d rd=%h want wr=%b stall=%b addr=%0d rd=%h",
                     o_wr, o_stall, o_rd_addr, o_rd, want[38], want[37], want[36:32], want[31:0]);
        end
        drive(1, 0, 1, 3'd0, 5'd4, 32'h0000_0077, 2'd0, 32'h0, 0);
        tick();
        clear_inputs();
        want = {1'b1, 1'b0, 5'd4, 32'h0000_0077};
        total++;
        if ({o_wr, o_stall, o_rd_addr, o_rd} !== want) begin
            bad++;
            $display("FAIL reset_wait_idle: got wr=%b stall=%b addr=%0d rd=%h want wr=%b stall=%b addr=%0d rd=%h",
                     o_wr, o_stall, o_rd_addr, o_rd, want[38], want[37], want[36:32], want[31:0]);
        end
    endtask

    task automatic test_random();
        logic        m_pend;
        logic [2:0]  m_f3;
        logic [1:0]  m_lsb;
        logic [4:0]  m_rd;
        logic        m_wr;
        logic        c_done, c_wr;
        logic [4:0]  c_rd;
        logic [31:0] c_val;
        logic        e_wr, e_stall;
        logic [4:0]  e_addr;
        logic [31:0] e_rd;
        do_reset();
        m_pend = 0; m_f3 = 0; m_lsb = 0; m_rd = 0; m_wr = 0;
        e_wr = 0; e_stall = 0; e_addr = 0; e_rd = 0;
        for (int n = 0; n < 600; n++) begin
            i_ce        = ($urandom_range(0, 9) < 7);
            i_stall     = ($urandom_range(0, 9) == 0);
            i_flush     = ($urandom_range(0, 9) == 0);
            i_is_load   = ($urandom_range(0, 1) == 1);
            i_wr_rd     = ($urandom_range(0, 9) < 8);
            i_funct3    = 3'($urandom_range(0, 7));
            i_rd_addr   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            i_result    = $urandom;
            i_addr_lsb  = 2'($urandom_range(0, 3));
            i_dmem_data = $urandom;
            i_dmem_ack  = ($urandom_range(0, 9) < 4);

            c_done = 0; c_wr = 0; c_rd = 0; c_val = 0;
            if (m_pend) begin
                if (i_dmem_ack) begin
                    c_done = 1; c_wr = m_wr; c_rd = m_rd;
                    c_val  = ref_load(m_f3, m_lsb, i_dmem_data);
                    m_pend = 0;
                end
            end else if (i_ce && !i_stall && !i_flush) begin
                if (!i_is_load) begin
                    c_done = 1; c_wr = i_wr_rd; c_rd = i_rd_addr; c_val = i_result;
                end else if (i_dmem_ack) begin
                    c_done = 1; c_wr = i_wr_rd; c_rd = i_rd_addr;
                    c_val  = ref_load(i_funct3, i_addr_lsb, i_dmem_data);
                end else begin
                    m_pend = 1; m_f3 = i_funct3; m_lsb = i_addr_lsb; m_rd = i_rd_addr; m_wr = i_wr_rd;
                end
            end
            e_wr = c_done && c_wr && (c_rd != 5'd0);
            if (e_wr) begin
                e_rd = c_val;
                e_addr = c_rd;
            end
            e_stall = m_pend;

            tick();
            total++;
            if ({o_wr, o_stall, o_rd_addr, o_rd} !== {e_wr, e_stall, e_addr, e_rd}) begin
                bad++;
                $display("FAIL random[%0d]: got wr=%b stall=%b addr=%0d rd=%h want wr=%b stall=%b addr=%0d rd=%h",
                         n, o_wr, o_stall, o_rd_addr, o_rd, e_wr, e_stall, e_addr, e_rd);
            end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        i_rstn = 1'b1;
        test_reset();
        test_alu();
        test_load_ack();
        test_load_delayed();
        test_no_write();
        test_flush_in_wait();
        test_reset_in_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
